// File: rtl/ff_share_arbiter.sv
// Two-requester round-robin arbiter feeding one shared registered stage.
// The registered word carries its source index and drains through a valid/ready port.
module ff_share_arbiter #(
    parameter int WIDTH = 8,
    parameter int BURST = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [1:0]       req_valid,
    input  logic [WIDTH-1:0] req_data0,
    input  logic [WIDTH-1:0] req_data1,
    output logic [1:0]       req_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready
);

    localparam int CW = $clog2(BURST + 1);
    localparam logic [CW-1:0] BURST_C = CW'(BURST);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_src_q, out_src_d;
    logic             prio_q, prio_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             load;
    logic [1:0]       grant;
    logic             accept;
    logic             acc_src;
    logic [CW-1:0]    cnt_inc;

    // The register can take a new word when empty or being drained this cycle.
    assign load = ~out_valid_q | out_ready;

    always_comb begin
        grant = 2'b00;
        unique case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    assign req_ready = (load & ~RESET) ? grant : 2'b00;
    assign accept    = |req_ready;
    assign acc_src   = req_ready[1];
    assign cnt_inc   = (acc_src == prio_q) ? (cnt_q + CW'(1)) : CW'(1);

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        prio_d      = prio_q;
        cnt_d       = cnt_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = acc_src ? req_data1 : req_data0;
            out_src_d   = acc_src;
            // A completed burst hands priority to the other requester.
            if (cnt_inc == BURST_C) begin
                prio_d = ~acc_src;
                cnt_d  = '0;
            end else begin
                prio_d = acc_src;
                cnt_d  = cnt_inc;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 1'b0;
            prio_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            prio_q      <= prio_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

    a_lat0: assert property (@(posedge CLK) disable iff (RESET)
        (req_valid[0] & req_ready[0]) |=>
            (out_valid && out_data == $past(req_data0) && out_src == 1'b0));

    a_lat1: assert property (@(posedge CLK) disable iff (RESET)
        (req_valid[1] & req_ready[1]) |=>
            (out_valid && out_data == $past(req_data1) && out_src == 1'b1));

    a_stable: assert property (@(posedge CLK) disable iff (RESET)
        (out_valid & ~out_ready) |=>
            ($stable(out_data) && $stable(out_src) && out_valid));

    a_onehot: assert property (@(posedge CLK) req_ready != 2'b11);

    a_cnt: assert property (@(posedge CLK) disable iff (RESET) cnt_q < BURST_C);

endmodule

// File: tb/tb_ff_share_arbiter.sv
// Randomized scoreboard bench for ff_share_arbiter; two instances (BURST=3 and BURST=1)
// share one stimulus stream and are each checked against a reference model.
module tb_ff_share_arbiter;

    localparam int W = 8;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [1:0]   rv;
    logic [W-1:0] d0, d1;
    logic         ordy;

    logic [1:0]   rr_a, rr_b;
    logic         ov_a, ov_b;
    logic [W-1:0] od_a, od_b;
    logic         os_a, os_b;

    ff_share_arbiter #(.WIDTH(W), .BURST(3)) u_b3 (
        .CLK(clk), .RESET(rst), .req_valid(rv), .req_data0(d0), .req_data1(d1),
        .req_ready(rr_a), .out_valid(ov_a), .out_data(od_a), .out_src(os_a),
        .out_ready(ordy)
    );

    ff_share_arbiter #(.WIDTH(W), .BURST(1)) u_b1 (
        .CLK(clk), .RESET(rst), .req_valid(rv), .req_data0(d0), .req_data1(d1),
        .req_ready(rr_b), .out_valid(ov_b), .out_data(od_b), .out_src(os_b),
        .out_ready(ordy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state per instance: preferred requester and grants in current run.
    int         burst_of [2] = '{3, 1};
    int         prio_m   [2] = '{0, 0};
    int         run_m    [2] = '{0, 0};
    bit         pend     [2] = '{0, 0};
    logic [8:0] pend_item[2];
    logic [8:0] q0[$];
    logic [8:0] q1[$];

    function automatic int qsize(int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [8:0] qfront(int k);
        return (k == 0) ? q0[0] : q1[0];
    endfunction

    task automatic qpush(int k, logic [8:0] v);
        if (k == 0) q0.push_back(v); else q1.push_back(v);
    endtask

    task automatic qpop(int k);
        if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    endtask

    task automatic qflush(int k);
        if (k == 0) q0.delete(); else q1.delete();
    endtask

    function automatic logic [1:0] g_rr(int k);
        return (k == 0) ? rr_a : rr_b;
    endfunction
    function automatic logic g_ov(int k);
        return (k == 0) ? ov_a : ov_b;
    endfunction
    function automatic logic [W-1:0] g_od(int k);
        return (k == 0) ? od_a : od_b;
    endfunction
    function automatic logic g_os(int k);
        return (k == 0) ? os_a : os_b;
    endfunction

    task automatic check(string name, int k, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s burst=%0d t=%0t: got %0h expected %0h",
                     name, burst_of[k], $time, act, exp);
        end
    endtask

    // One bus cycle: commit last cycle's prediction, drive new inputs, predict this cycle.
    task automatic cycle(input logic r, input logic [1:0] v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic o);
        bit was_rst;
        @(posedge clk);
        was_rst = rst;
        for (int k = 0; k < 2; k++) begin
            if (was_rst) begin
                qflush(k);
                prio_m[k] = 0;
                run_m[k]  = 0;
            end else if (pend[k]) begin
                qpush(k, pend_item[k]);
            end
            pend[k] = 1'b0;
        end
        #2;
        rst = r; rv = v; d0 = a; d1 = b; ordy = o;
        #1;
        for (int k = 0; k < 2; k++) begin
            logic [1:0] exp;
            bit         load;
            int         s;
            int         run;
            exp = 2'b00;
            if (was_rst) begin
                check("reset_out_valid", k, 32'(g_ov(k)), 32'd0);
                check("reset_out_data", k, 32'(g_od(k)), 32'd0);
                check("reset_out_src", k, 32'(g_os(k)), 32'd0);
            end
            load = (qsize(k) == 0) || o;
            if (!r && load && v != 2'b00) begin
                s = (v == 2'b11) ? prio_m[k] : ((v == 2'b10) ? 1 : 0);
                exp = (s == 1) ? 2'b10 : 2'b01;
                run = (s == prio_m[k]) ? run_m[k] + 1 : 1;
                if (run == burst_of[k]) begin
                    prio_m[k] = 1 - s;
                    run_m[k]  = 0;
                end else begin
                    prio_m[k] = s;
                    run_m[k]  = run;
                end
                pend[k]      = 1'b1;
                pend_item[k] = {s[0], (s == 1) ? b : a};
            end
            check("req_ready", k, 32'(g_rr(k)), 32'(exp));
        end
    endtask

    // Monitor: compares the presented word against the scoreboard, pops on handshake.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                check("out_valid", k, 32'(g_ov(k)), 32'(qsize(k) != 0));
                if (g_ov(k) && qsize(k) != 0) begin
                    check("out_data", k, 32'(g_od(k)), 32'(qfront(k) & 9'h0FF));
                    check("out_src", k, 32'(g_os(k)), 32'(qfront(k) >> 8));
                    if (ordy) qpop(k);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; rv = 2'b00; d0 = '0; d1 = '0; ordy = 1'b0;

        // Reset held two cycles with both requesters valid.
        cycle(1, 2'b11, 8'hE0, 8'hE1, 1);
        cycle(1, 2'b11, 8'hE2, 8'hE3, 1);

        // Round robin: both valid, out_ready high for 6 cycles.
        for (int i = 0; i < 6; i++)
            cycle(0, 2'b11, W'(8'h40 + i), W'(8'h80 + i), 1);
        cycle(0, 2'b00, 8'h00, 8'h00, 1);
        cycle(1, 2'b00, 8'h00, 8'h00, 1);

        // Single requester streaming 0x11, 0x22, 0x33.
        cycle(0, 2'b01, 8'h11, 8'h00, 1);
        cycle(0, 2'b01, 8'h22, 8'h00, 1);
        cycle(0, 2'b01, 8'h33, 8'h00, 1);
        cycle(0, 2'b00, 8'h00, 8'h00, 1);

        // Back-pressure: 0xA5 from requester 1, held 3 cycles, then 0x5A with no bubble.
        cycle(0, 2'b10, 8'h00, 8'hA5, 1);
        for (int i = 0; i < 3; i++)
            cycle(0, 2'b01, 8'h5A, 8'h00, 0);
        cycle(0, 2'b01, 8'h5A, 8'h00, 1);
        cycle(0, 2'b00, 8'h00, 8'h00, 1);

        // Reset while a word is held under back-pressure.
        cycle(0, 2'b10, 8'h00, 8'h77, 0);
        cycle(0, 2'b00, 8'h00, 8'h00, 0);
        cycle(1, 2'b00, 8'h00, 8'h00, 0);
        cycle(0, 2'b11, 8'h12, 8'h34, 1);
        cycle(0, 2'b00, 8'h00, 8'h00, 1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 59) == 0),
                  2'($urandom_range(0, 3)),
                  W'($urandom_range(0, 255)),
                  W'($urandom_range(0, 255)),
                  ($urandom_range(0, 3) != 0));
        end

        for (int i = 0; i < 4; i++)
            cycle(0, 2'b00, 8'h00, 8'h00, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
